// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store initiator: access sizes, FSM states,
// and the alignment/size helpers used by the top level.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    // Size code 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic is_subword(input logic [1:0] size);
        is_subword = (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane steering: pulls a byte/half/word out of a RAM word with
// sign or zero extension, and merges store data into an existing word.
module byte_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_new,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_extract,
    output logic [31:0] o_merge
);

    logic [15:0] w_low;

    always_comb begin
        w_low = 16'(i_word >> {i_off, 3'b000});
        case (i_size)
            SZ_BYTE: o_extract = {{24{i_signed & w_low[7]}}, w_low[7:0]};
            SZ_HALF: o_extract = {{16{i_signed & w_low[15]}}, w_low};
            default: o_extract = i_word;
        endcase
    end

    always_comb begin
        o_merge = i_word;
        case (i_size)
            SZ_BYTE: o_merge[{i_off, 3'b000} +: 8] = i_new[7:0];
            SZ_HALF: begin
                if (i_off[1]) o_merge[31:16] = i_new[15:0];
                else          o_merge[15:0]  = i_new[15:0];
            end
            default: o_merge = i_new;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for a word-wide RAM; sub-word stores
// are done as read-modify-write because the RAM only writes whole words.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_data_write,
    output logic                  o_mem_write_en,
    output logic                  o_mem_read_en,
    input  logic [DATA_WIDTH-1:0] i_mem_data_in
);

    state_t                r_state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_data_write;
    logic                  r_mem_write_en;
    logic                  r_mem_read_en;

    logic [31:0]           w_extract;
    logic [31:0]           w_merge;

    byte_lane_align u_lane (
        .i_word    (i_mem_data_in),
        .i_new     (r_wdata),
        .i_off     (r_off),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .o_extract (w_extract),
        .o_merge   (w_merge)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state          <= ST_INIT;
            r_we             <= 1'b0;
            r_size           <= SZ_BYTE;
            r_signed         <= 1'b0;
            r_off            <= 2'b00;
            r_wdata          <= '0;
            r_req_ready      <= 1'b0;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= '0;
            r_resp_err       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_data_write <= '0;
            r_mem_write_en   <= 1'b0;
            r_mem_read_en    <= 1'b0;
        end else begin
            case (r_state)
                // One dead cycle while the RAM performs its initial load.
                ST_INIT: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_req_ready   <= 1'b0;
                        r_we          <= i_req_we;
                        r_size        <= i_req_size;
                        r_signed      <= i_req_signed;
                        r_off         <= i_req_addr[1:0];
                        r_wdata       <= i_req_wdata;
                        r_mem_address <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (is_misaligned(i_req_size, i_req_addr[1:0])) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!i_req_we || is_subword(i_req_size)) begin
                            r_state       <= ST_READ;
                            r_mem_read_en <= 1'b1;
                        end else begin
                            r_state          <= ST_WRITE;
                            r_mem_write_en   <= 1'b1;
                            r_mem_data_write <= i_req_wdata;
                        end
                    end
                end
                ST_READ: begin
                    r_mem_read_en <= 1'b0;
                    if (r_we) begin
                        r_state          <= ST_WRITE;
                        r_mem_write_en   <= 1'b1;
                        r_mem_data_write <= w_merge;
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_extract;
                    end
                end
                ST_WRITE: begin
                    r_state        <= ST_RESP;
                    r_mem_write_en <= 1'b0;
                    r_resp_valid   <= 1'b1;
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready      = r_req_ready;
    assign o_resp_valid     = r_resp_valid;
    assign o_resp_rdata     = r_resp_rdata;
    assign o_resp_err       = r_resp_err;
    assign o_mem_address    = r_mem_address;
    assign o_mem_data_write = r_mem_data_write;
    assign o_mem_write_en   = r_mem_write_en;
    assign o_mem_read_en    = r_mem_read_en;

endmodule
